// File: rtl/multiplier_alu_if.sv
// +---------------------------------------------------------------------------+
// | multiplier_alu_if : request/response bundle for the iterative multiplier  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

interface multiplier_alu_if #(
    parameter int XLEN = 64
);
    logic            valid;
    logic            ready;
    logic [1:0]      mul_op;
    logic            word_op;
    logic [4:0]      rd;
    logic [4:0]      alu_control;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic [XLEN-1:0] result;
    logic [4:0]      out_rd;
    logic [4:0]      out_alu_control;

    modport master (
        output valid, mul_op, word_op, rd, alu_control, a, b,
        input  ready, out_valid, result, out_rd, out_alu_control
    );

    modport slave (
        input  valid, mul_op, word_op, rd, alu_control, a, b,
        output ready, out_valid, result, out_rd, out_alu_control
    );
endinterface

`default_nettype wire

// File: rtl/multiplier_alu.sv
// +---------------------------------------------------------------------------+
// | multiplier_alu : iterative shift-add RV64M multiplier (MUL/MULH/MULHSU/   |
// | MULHU), magnitude multiply with final two's-complement fixup.             |
// | Optional MULW path enabled by defining MUL_WORD_EN.                       |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module multiplier_alu #(
    parameter int XLEN           = 64,
    parameter int BITS_PER_CYCLE = 1
) (
    input  wire             clk,
    input  wire             rst,
    multiplier_alu_if.slave bus
);
    localparam int N    = XLEN / BITS_PER_CYCLE;
    localparam int HALF = XLEN / 2;
    localparam int AW   = 2 * XLEN;
    localparam int CW   = $clog2(N + 1);
    localparam int SW   = $clog2(AW);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] a_mag_q, a_mag_d;
    logic [XLEN-1:0] b_mag_q, b_mag_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic            neg_q, neg_d;
    logic            word_q, word_d;
    logic [1:0]      op_q, op_d;
    logic [4:0]      rd_q, rd_d;
    logic [4:0]      alu_q, alu_d;
    logic [CW-1:0]   count_q, count_d;

    logic            w_ready;
    logic            w_word_req;
    logic            w_a_sgn, w_b_sgn;
    logic            w_a_neg, w_b_neg;
    logic [XLEN-1:0] w_a_ext, w_b_ext;
    logic [XLEN-1:0] w_a_abs, w_b_abs;
    logic [AW-1:0]   w_pp;
    logic [AW-1:0]   w_p;
    logic [SW-1:0]   w_shift;
    logic [CW-1:0]   w_last;
    logic [XLEN-1:0] w_result;

`ifdef MUL_WORD_EN
    assign w_word_req = bus.word_op && (bus.mul_op == 2'b00);
`else
    logic w_unused_word_op;
    assign w_unused_word_op = bus.word_op;
    assign w_word_req       = 1'b0;
`endif

    // Word ops treat both 32-bit operands as signed; otherwise signedness follows mul_op.
    assign w_a_sgn = w_word_req | (bus.mul_op != 2'b11);
    assign w_b_sgn = w_word_req | ~bus.mul_op[1];
    assign w_a_ext = w_word_req ? {{HALF{bus.a[HALF-1]}}, bus.a[HALF-1:0]} : bus.a;
    assign w_b_ext = w_word_req ? {{HALF{bus.b[HALF-1]}}, bus.b[HALF-1:0]} : bus.b;
    assign w_a_neg = w_a_sgn & w_a_ext[XLEN-1];
    assign w_b_neg = w_b_sgn & w_b_ext[XLEN-1];
    assign w_a_abs = w_a_neg ? (~w_a_ext + XLEN'(1)) : w_a_ext;
    assign w_b_abs = w_b_neg ? (~w_b_ext + XLEN'(1)) : w_b_ext;

    assign w_ready = (state_q == S_IDLE) || (state_q == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_mag_q <= '0;
            b_mag_q <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            word_q  <= 1'b0;
            op_q    <= '0;
            rd_q    <= '0;
            alu_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            a_mag_q <= a_mag_d;
            b_mag_q <= b_mag_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            word_q  <= word_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            alu_q   <= alu_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_mag_d = a_mag_q;
        b_mag_d = b_mag_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        word_d  = word_q;
        op_d    = op_q;
        rd_d    = rd_q;
        alu_d   = alu_q;
        count_d = count_q;

        w_pp = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (a_mag_q[i]) begin
                w_pp = w_pp + ({{XLEN{1'b0}}, b_mag_q} << i);
            end
        end
        w_shift = SW'(count_q) * SW'(BITS_PER_CYCLE);
        w_last  = word_q ? CW'(N / 2 - 1) : CW'(N - 1);

        case (state_q)
            S_BUSY: begin
                acc_d   = acc_q + (w_pp << w_shift);
                a_mag_d = a_mag_q >> BITS_PER_CYCLE;
                count_d = count_q + CW'(1);
                if (count_q == w_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: ;
        endcase

        // A request in DONE starts the next op on the same edge, giving zero bubble.
        if (w_ready && bus.valid) begin
            state_d = S_BUSY;
            a_mag_d = w_a_abs;
            b_mag_d = w_b_abs;
            neg_d   = w_a_neg ^ w_b_neg;
            word_d  = w_word_req;
            op_d    = bus.mul_op;
            rd_d    = bus.rd;
            alu_d   = bus.alu_control;
            acc_d   = '0;
            count_d = '0;
        end
    end

    assign w_p = neg_q ? (~acc_q + AW'(1)) : acc_q;

    always_comb begin
        w_result = '0;
        if (state_q == S_DONE) begin
            if (word_q) begin
                w_result = {{HALF{w_p[HALF-1]}}, w_p[HALF-1:0]};
            end else if (op_q == 2'b00) begin
                w_result = w_p[XLEN-1:0];
            end else begin
                w_result = w_p[AW-1:XLEN];
            end
        end
    end

    assign bus.ready           = w_ready;
    assign bus.out_valid       = (state_q == S_DONE);
    assign bus.result          = w_result;
    assign bus.out_rd          = rd_q;
    assign bus.out_alu_control = alu_q;

endmodule

`default_nettype wire

// File: tb/tb_multiplier_alu.sv
// Scoreboard bench for multiplier_alu: reference products from wide signed arithmetic,
// monitor compares result, tags and accept-to-valid latency.
`default_nettype none

module tb_multiplier_alu;
    localparam int XLEN = 64;
    localparam int N    = 64;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        logic [4:0]  alu;
        int unsigned acc_cyc;
        int unsigned lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    exp_t        q[$];

    multiplier_alu_if #(.XLEN(XLEN)) bus ();

    multiplier_alu #(.XLEN(XLEN), .BITS_PER_CYCLE(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic word_eff(input logic [1:0] op, input logic w);
`ifdef MUL_WORD_EN
        return w && (op == 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [63:0] model(input logic [1:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic signed [129:0] sa, sb, p;
        if (word_eff(op, w)) begin
            sa = $signed({{98{a[31]}}, a[31:0]});
            sb = $signed({{98{b[31]}}, b[31:0]});
            p  = sa * sb;
            return {{32{p[31]}}, p[31:0]};
        end
        sa = (op != 2'b11) ? $signed({{66{a[63]}}, a}) : $signed({66'b0, a});
        sb = (op[1] == 1'b0) ? $signed({{66{b[63]}}, b}) : $signed({66'b0, b});
        p  = sa * sb;
        return (op == 2'b00) ? p[63:0] : p[127:64];
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out_valid: got result %h expected no output", bus.result);
                end else begin
                    e = q.pop_front();
                    chk("result", bus.result, e.res);
                    chk("out_rd", 64'(bus.out_rd), 64'(e.rd));
                    chk("out_alu_control", 64'(bus.out_alu_control), 64'(e.alu));
                    chk("latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
                end
            end else begin
                chk("result_zero_when_idle", bus.result, 64'd0);
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd, input logic [4:0] alu);
        exp_t e;
        bit   ok;
        int   guard;
        bus.valid       = 1'b1;
        bus.mul_op      = op;
        bus.word_op     = w;
        bus.a           = a;
        bus.b           = b;
        bus.rd          = rd;
        bus.alu_control = alu;
        ok    = 1'b0;
        guard = 0;
        while (!ok) begin
            ok = bus.ready;
            @(posedge clk);
            #1;
            guard++;
            if (guard > 500) begin
                $display("FAIL accept_timeout: got ready=0 for 500 cycles expected ready=1");
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_bad + 1);
                $fatal(1, "accept timeout");
            end
        end
        e.res     = model(op, w, a, b);
        e.rd      = rd;
        e.alu     = alu;
        e.acc_cyc = cyc;
        e.lat     = word_eff(op, w) ? N / 2 : N;
        q.push_back(e);
        chk("ready_low_in_busy", 64'(bus.ready), 64'd0);
    endtask

    task automatic idle();
        bus.valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        idle();
        guard = 0;
        while (q.size() != 0 && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 6))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'd1;
            3:       return 64'h8000_0000_0000_0000;
            4:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        bus.valid       = 1'b0;
        bus.mul_op      = 2'b00;
        bus.word_op     = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        bus.rd          = '0;
        bus.alu_control = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 64'(bus.ready), 64'd1);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_result", bus.result, 64'd0);
        chk("reset_out_rd", 64'(bus.out_rd), 64'd0);
        chk("reset_out_alu", 64'(bus.out_alu_control), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(2'b00, 1'b0, 64'd7, -64'sd3, 5'd1, 5'd2);
        drain();
        issue(2'b11, 1'b0, '1, '1, 5'd4, 5'd5);
        issue(2'b01, 1'b0, '1, '1, 5'd6, 5'd7);
        issue(2'b00, 1'b0, '1, '1, 5'd8, 5'd9);
        issue(2'b10, 1'b0, '1, '1, 5'd10, 5'd11);
        issue(2'b01, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd12, 5'd13);
        issue(2'b01, 1'b0, 64'd0, -64'sd5, 5'd14, 5'd15);
        issue(2'b00, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd16, 5'd17);
        drain();

        issue(2'b00, 1'b0, 64'd11, 64'd13, 5'd3, 5'd20);
        issue(2'b11, 1'b0, 64'd17, 64'd19, 5'd9, 5'd21);
        drain();

        issue(2'b01, 1'b0, 64'h1234_5678_9ABC_DEF0, -64'sd77, 5'd17, 5'd22);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        idle();
        #1;
        chk("midop_reset_ready", 64'(bus.ready), 64'd1);
        chk("midop_reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midop_reset_out_rd", 64'(bus.out_rd), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        issue(2'b10, 1'b0, -64'sd9, 64'hF000_0000_0000_0001, 5'd25, 5'd26);
        drain();

        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), pick(), pick(),
                  5'($urandom), 5'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                idle();
                repeat ($urandom_range(1, 70)) @(posedge clk);
                #1;
            end
        end
        drain();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
